// File: rtl/tiny_dnn_dst_serializer_if.sv
// Stream bundle between the two-lane result port, the serializer and the one-lane consumer.
// Real values travel as their IEEE-754 binary64 bit pattern ($realtobits / $bitstoreal).
interface tiny_dnn_dst_serializer_if;
  logic        dst_valid;
  logic [63:0] dst_data0;
  logic [63:0] dst_data1;
  logic [15:0] dst_ptr0;
  logic [15:0] dst_ptr1;
  logic        dst_last;
  logic        odd;
  logic        dst_ready;

  logic        m_valid;
  logic [63:0] m_data;
  logic [15:0] m_ptr;
  logic        m_last;
  logic        m_ready;

  // Serializer view.
  modport slave (
    input  dst_valid, dst_data0, dst_data1, dst_ptr0, dst_ptr1, dst_last, odd, m_ready,
    output dst_ready, m_valid, m_data, m_ptr, m_last
  );

  // Environment view: upstream producer plus downstream consumer.
  modport master (
    output dst_valid, dst_data0, dst_data1, dst_ptr0, dst_ptr1, dst_last, odd, m_ready,
    input  dst_ready, m_valid, m_data, m_ptr, m_last
  );
endinterface

// File: rtl/tiny_dnn_dst_serializer.sv
// Two-lane to one-lane serializer: buffers result beats in a first-word fall-through FIFO
// and emits lane 0 then lane 1 of each beat, skipping lane 1 of an odd final beat.
module tiny_dnn_dst_serializer #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  tiny_dnn_dst_serializer_if.slave        bus,
  output logic [$clog2(DEPTH):0]          count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] data0;
    logic [63:0] data1;
    logic [15:0] ptr0;
    logic [15:0] ptr1;
    logic        last;
    logic        single;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_lane;

  entry_t        w_head;
  logic          w_ready;
  logic          w_valid;
  logic          w_push;
  logic          w_accept;
  logic          w_pop;
  logic [CW-1:0] w_count_d;
  logic          w_lane_d;

  // Full-ness comes from the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    w_ready  = ~rst & (r_count != FullCount);
    w_push   = bus.dst_valid & w_ready;
    w_valid  = (r_count != '0);
    w_head   = r_mem[r_rd_ptr];
    w_accept = w_valid & bus.m_ready;
    w_pop    = w_accept & (r_lane | w_head.single);
  end

  always_comb begin
    bus.dst_ready = w_ready;
    bus.m_valid   = w_valid;
    bus.m_data    = '0;
    bus.m_ptr     = '0;
    bus.m_last    = 1'b0;
    if (w_valid) begin
      bus.m_data = r_lane ? w_head.data1 : w_head.data0;
      bus.m_ptr  = r_lane ? w_head.ptr1 : w_head.ptr0;
      bus.m_last = w_head.last & (r_lane | w_head.single);
    end
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
    w_lane_d = r_lane;
    if (w_accept) begin
      w_lane_d = ~w_pop;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{
        data0:  bus.dst_data0,
        data1:  bus.dst_data1,
        ptr0:   bus.dst_ptr0,
        ptr1:   bus.dst_ptr1,
        last:   bus.dst_last,
        single: bus.dst_last & bus.odd
      };
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_lane   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_d;
      r_lane  <= w_lane_d;
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_tiny_dnn_dst_serializer.sv
// Self-checking bench for tiny_dnn_dst_serializer: the model is a queue of expected output
// words, filled per accepted beat and drained per accepted word.
module tb_tiny_dnn_dst_serializer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned VW    = 83 + CW;

  typedef struct {
    logic [63:0] data;
    logic [15:0] ptr;
    logic        last;
    logic        beat_end;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] count;
  logic [VW-1:0] obs;
  logic [81:0]   mfields;
  int            n_checks = 0;
  int            n_pass   = 0;
  word_t         q[$];

  tiny_dnn_dst_serializer_if bus ();

  tiny_dnn_dst_serializer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  assign obs     = {bus.dst_ready, bus.m_valid, bus.m_data, bus.m_ptr, bus.m_last, count};
  assign mfields = {bus.m_valid, bus.m_data, bus.m_ptr, bus.m_last};

  function automatic int beats();
    int n = 0;
    foreach (q[i]) if (q[i].beat_end) n++;
    return n;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic rdy;
    rdy = !rst && (beats() < int'(DEPTH));
    if (q.size() == 0) return {rdy, 1'b0, 64'd0, 16'd0, 1'b0, CW'(0)};
    return {rdy, 1'b1, q[0].data, q[0].ptr, q[0].last, CW'(beats())};
  endfunction

  function automatic void model_push(input logic [63:0] d0, input logic [63:0] d1,
                                     input logic [15:0] p0, input logic [15:0] p1,
                                     input logic last, input logic odd);
    word_t w;
    logic  s;
    s = last & odd;
    w.data = d0; w.ptr = p0; w.last = s; w.beat_end = s;
    q.push_back(w);
    if (!s) begin
      w.data = d1; w.ptr = p1; w.last = last; w.beat_end = 1'b1;
      q.push_back(w);
    end
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drive_beat(input logic v, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [15:0] p0, input logic [15:0] p1,
                            input logic last, input logic odd);
    bus.dst_valid = v;
    bus.dst_data0 = d0;
    bus.dst_data1 = d1;
    bus.dst_ptr0  = p0;
    bus.dst_ptr1  = p1;
    bus.dst_last  = last;
    bus.odd       = odd;
  endtask

  // Advance one clock and update the model with what the spec says happens at that edge.
  task automatic tick();
    logic acc, psh, l, o;
    logic [63:0] d0, d1;
    logic [15:0] p0, p1;
    acc = (q.size() != 0) && bus.m_ready && !rst;
    psh = bus.dst_valid && !rst && (beats() < int'(DEPTH));
    d0 = bus.dst_data0; d1 = bus.dst_data1; p0 = bus.dst_ptr0; p1 = bus.dst_ptr1;
    l = bus.dst_last; o = bus.odd;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (acc) void'(q.pop_front());
      if (psh) model_push(d0, d1, p0, p1, l, o);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.m_ready = 1'b1;
    drive_beat(1'b1, rnd64(), rnd64(), 16'h1, 16'h2, 1'b1, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (obs !== VW'(0)) $display("FAIL reset_hold: got %h want %h", obs, VW'(0));
    else n_pass++;
    rst = 1'b0;
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (obs !== {1'b1, (VW-1)'(0)}) $display("FAIL reset_release: got %h want %h",
                                             obs, {1'b1, (VW-1)'(0)});
    else n_pass++;
  endtask

  task automatic test_single_beat();
    bus.m_ready = 1'b1;
    drive_beat(1'b1, $realtobits(1.0), $realtobits(2.0), 16'd3, 16'd4, 1'b1, 1'b0);
    tick();
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    n_checks++;
    if (mfields !== {1'b1, $realtobits(1.0), 16'd3, 1'b0})
      $display("FAIL single_word0: got %h want %h", mfields, {1'b1, $realtobits(1.0), 16'd3, 1'b0});
    else n_pass++;
    tick();
    n_checks++;
    if (mfields !== {1'b1, $realtobits(2.0), 16'd4, 1'b1})
      $display("FAIL single_word1: got %h want %h", mfields, {1'b1, $realtobits(2.0), 16'd4, 1'b1});
    else n_pass++;
    tick();
    n_checks++;
    if ({bus.m_valid, count} !== {1'b0, CW'(0)})
      $display("FAIL single_empty: got %h want %h", {bus.m_valid, count}, {1'b0, CW'(0)});
    else n_pass++;
  endtask

  task automatic test_odd_packet();
    int          n_words = 0;
    int          n_last  = 0;
    logic [63:0] last_data = '0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(1'b1, (i == 2) ? $realtobits(5.0) : rnd64(), rnd64(), 16'($urandom),
                 16'($urandom), i == 2, i == 2);
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL odd_push: got %h want %h", obs, exp_vec());
      else n_pass++;
      if (bus.m_valid) begin
        n_words++;
        if (bus.m_last) begin n_last++; last_data = bus.m_data; end
      end
    end
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL odd_drain: got %h want %h", obs, exp_vec());
      else n_pass++;
      if (bus.m_valid) begin
        n_words++;
        if (bus.m_last) begin n_last++; last_data = bus.m_data; end
      end
    end
    n_checks++;
    if ({n_words, n_last, last_data} !== {32'sd5, 32'sd1, $realtobits(5.0)})
      $display("FAIL odd_words: got words=%0d lasts=%0d last_data=%h want 5 1 %h",
               n_words, n_last, last_data, $realtobits(5.0));
    else n_pass++;
  endtask

  task automatic test_full();
    int n_words = 0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive_beat(1'b1, rnd64(), rnd64(), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      tick();
    end
    n_checks++;
    if ({count, bus.dst_ready} !== {CW'(DEPTH), 1'b0})
      $display("FAIL full_state: got count=%0d ready=%b want %0d 0", count, bus.dst_ready, DEPTH);
    else n_pass++;
    drive_beat(1'b1, rnd64(), rnd64(), 16'hdead, 16'hbeef, 1'b1, 1'b0);
    repeat (3) tick();
    n_checks++;
    if (obs !== exp_vec() || count !== CW'(DEPTH))
      $display("FAIL full_no_take: got %h want %h", obs, exp_vec());
    else n_pass++;
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    bus.m_ready = 1'b1;
    if (bus.m_valid) n_words++;
    tick();
    n_checks++;
    if (bus.dst_ready !== 1'b0) $display("FAIL full_ready_lane1: got %b want 0", bus.dst_ready);
    else n_pass++;
    if (bus.m_valid) n_words++;
    tick();
    n_checks++;
    if (bus.dst_ready !== 1'b1) $display("FAIL full_ready_pop: got %b want 1", bus.dst_ready);
    else n_pass++;
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL full_drain: got %h want %h", obs, exp_vec());
      else n_pass++;
      if (bus.m_valid) n_words++;
      tick();
    end
    n_checks++;
    if (n_words != 2 * int'(DEPTH) || bus.m_valid !== 1'b0)
      $display("FAIL full_words: got %0d valid=%b want %0d 0", n_words, bus.m_valid, 2 * DEPTH);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int          pushed = 0;
    int          exp_words = 0;
    int          seen = 0;
    logic        stall, taken, last, odd;
    logic [81:0] prev;
    for (int c = 0; c < 3000 && (pushed < 100 || q.size() != 0); c++) begin
      if (!bus.dst_valid && pushed < 100) begin
        last = ($urandom_range(0, 3) == 0);
        odd  = 1'($urandom);
        drive_beat(1'b1, rnd64(), rnd64(), 16'($urandom), 16'($urandom), last, odd);
      end
      bus.m_ready = ($urandom_range(0, 9) < 3);
      taken = bus.dst_valid && (beats() < int'(DEPTH));
      if (taken) exp_words += (bus.dst_last && bus.odd) ? 1 : 2;
      stall = bus.m_valid && !bus.m_ready;
      if (bus.m_valid && bus.m_ready) seen++;
      prev  = mfields;
      tick();
      if (taken) begin
        pushed++;
        bus.dst_valid = 1'b0;
      end
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL bp_output: got %h want %h", obs, exp_vec());
      else n_pass++;
      if (stall) begin
        n_checks++;
        if (mfields !== prev) $display("FAIL bp_stable: got %h want %h", mfields, prev);
        else n_pass++;
      end
    end
    n_checks++;
    if (seen != exp_words || pushed != 100)
      $display("FAIL bp_words: got seen=%0d pushed=%0d want %0d 100", seen, pushed, exp_words);
    else n_pass++;
  endtask

  task automatic test_simul_push_pop();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_beat(1'b1, rnd64(), rnd64(), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    bus.m_ready = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp_vec() || count !== CW'(5))
      $display("FAIL sim_lane1: got %h want %h", obs, exp_vec());
    else n_pass++;
    drive_beat(1'b1, rnd64(), rnd64(), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
    tick();
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    bus.m_ready = 1'b0;
    n_checks++;
    if (obs !== exp_vec() || count !== CW'(5))
      $display("FAIL sim_push_pop: got %h want %h", obs, exp_vec());
    else n_pass++;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL sim_drain: got %h want %h", obs, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_packet();
    int          n_words = 0;
    logic [63:0] first_d0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_beat(1'b1, rnd64(), rnd64(), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.dst_ready, bus.m_valid, count} !== {1'b1, 1'b0, CW'(0)})
      $display("FAIL mid_reset: got ready=%b valid=%b count=%0d want 1 0 0",
               bus.dst_ready, bus.m_valid, count);
    else n_pass++;
    first_d0 = rnd64();
    bus.m_ready = 1'b1;
    drive_beat(1'b1, first_d0, rnd64(), 16'h0011, 16'h0022, 1'b0, 1'b0);
    tick();
    drive_beat(1'b1, rnd64(), rnd64(), 16'h0033, 16'h0044, 1'b1, 1'b0);
    n_checks++;
    if ({bus.m_data, bus.m_ptr} !== {first_d0, 16'h0011})
      $display("FAIL mid_first_word: got %h want %h", {bus.m_data, bus.m_ptr},
               {first_d0, 16'h0011});
    else n_pass++;
    if (bus.m_valid) n_words++;
    tick();
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    for (int c = 0; c < 20 && (q.size() != 0 || bus.m_valid); c++) begin
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL mid_drain: got %h want %h", obs, exp_vec());
      else n_pass++;
      if (bus.m_valid) n_words++;
      tick();
    end
    n_checks++;
    if (n_words != 4) $display("FAIL mid_words: got %0d want 4", n_words);
    else n_pass++;
  endtask

  initial begin
    bus.m_ready = 1'b0;
    drive_beat(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_single_beat();
    test_odd_packet();
    test_full();
    test_backpressure();
    test_simul_push_pop();
    test_reset_mid_packet();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
